// File: rtl/sc1_program_loader.sv
// sc1_program_loader: framed byte-stream loader for the SC1 program RAM.
// It assembles little-endian words into RAM and verifies an 8-bit checksum.
// The CPU is held in reset until a frame has loaded and passed its checksum.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | discard bytes until HEADER; HEADER starts a new frame
// S_LEN   | latch word count N (LEN=0 means 256), seed checksum with LEN
// S_DATA  | assemble 4 bytes per word, write RAM, count words down to 0
// S_SUM   | fold the checksum byte into the accumulator
// S_CHECK | one cycle, not ready: release the CPU or flag an error
module sc1_program_loader #(
  parameter int unsigned DEPTH_I = 8,
  parameter int unsigned WIDTH_I = 32,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [DEPTH_I-1:0] rom_addr,
  output logic [WIDTH_I-1:0] rom_data,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_error
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_SUM, S_CHECK} state_t;

  state_t               state, state_nxt;
  logic                 xfer;
  logic                 last_byte;
  logic [1:0]           byte_cnt;
  logic [8:0]           words_left;
  logic [DEPTH_I-1:0]   word_addr;
  logic [7:0]           acc;
  logic [WIDTH_I-9:0]   asm_q;
  logic                 wr_en;
  logic [DEPTH_I-1:0]   wr_addr;
  logic [WIDTH_I-1:0]   wr_data;
  logic [WIDTH_I-1:0]   mem [0:(2**DEPTH_I)-1];

  assign xfer      = rx_valid && rx_ready;
  assign last_byte = (byte_cnt == 2'd3);

  // State register; rx_ready is registered from the next state so it is low only in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rx_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_ready <= (state_nxt != S_CHECK);
    end
  end

  // Next-state decode; the word down-counter reaching its last word ends the data phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer && (rx_data == HEADER)) state_nxt = S_LEN;
      S_LEN:   if (xfer) state_nxt = S_DATA;
      S_DATA:  if (xfer && last_byte && (words_left == 9'd1)) state_nxt = S_SUM;
      S_SUM:   if (xfer) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: counters, checksum, word assembly, RAM write request and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      byte_cnt   <= '0;
      words_left <= '0;
      word_addr  <= '0;
      acc        <= '0;
      asm_q      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && (rx_data == HEADER)) begin
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            byte_cnt   <= '0;
            word_addr  <= '0;
            acc        <= '0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            words_left <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            acc        <= rx_data;
          end
        end
        S_DATA: begin
          if (xfer) begin
            acc      <= acc + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              wr_en      <= 1'b1;
              wr_addr    <= word_addr;
              wr_data    <= {rx_data, asm_q};
              word_addr  <= word_addr + DEPTH_I'(1);
              words_left <= words_left - 9'd1;
            end else begin
              asm_q <= {rx_data, asm_q[WIDTH_I-9:8]};
            end
          end
        end
        S_SUM: begin
          if (xfer) acc <= acc + rx_data;
        end
        S_CHECK: begin
          if (acc == 8'd0) begin
            load_done <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            load_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write one cycle after the 4th-byte handshake; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // CPU boot read port: registered read, always active.
  always_ff @(posedge clk) begin
    if (reset) rom_data <= '0;
    else       rom_data <= mem[rom_addr];
  end

endmodule

// File: tb/tb_sc1_program_loader.sv
// Directed bench for sc1_program_loader: frames with hand-computed checksums and readback.
module tb_sc1_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  acc;

  sc1_program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte and hold it until a handshake edge; returns #1 after that edge.
  task automatic send(input logic [7:0] b, input int gap);
    int   budget;
    logic took;
    tick(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    do begin
      took = rx_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!took && budget < 40);
    rx_valid = 1'b0;
    check("rx_handshake", {31'd0, took}, 32'd1);
  endtask

  task automatic read_word(input logic [7:0] a, input logic [31:0] exp, input string tag);
    rom_addr = a;
    tick(1);
    check(tag, rom_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rom_addr = 8'h00;

    // Reset values
    tick(3);
    check("rst_rx_ready",   {31'd0, rx_ready},   32'd0);
    check("rst_cpu_reset",  {31'd0, cpu_reset},  32'd1);
    check("rst_load_done",  {31'd0, load_done},  32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    check("rst_rom_data",   rom_data,            32'd0);
    reset = 1'b0;
    check("rel_rx_ready_before", {31'd0, rx_ready}, 32'd0);
    tick(1);
    check("rel_rx_ready_after",  {31'd0, rx_ready}, 32'd1);

    // Single-word load: A5 01 78 56 34 12 EB
    send(8'hA5, 0);
    check("w1_hdr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("w1_hdr_done",      {31'd0, load_done}, 32'd0);
    send(8'h01, 0);
    send(8'h78, 0);
    send(8'h56, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'hEB, 0);
    check("w1_sumT_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("w1_sumT_rx_ready",  {31'd0, rx_ready},  32'd0);
    check("w1_sumT_done",      {31'd0, load_done}, 32'd0);
    tick(1);
    check("w1_cpu_reset", {31'd0, cpu_reset},  32'd0);
    check("w1_done",      {31'd0, load_done},  32'd1);
    check("w1_error",     {31'd0, load_error}, 32'd0);
    check("w1_rx_ready",  {31'd0, rx_ready},   32'd1);
    read_word(8'd0, 32'h12345678, "w1_word0");

    // Bad checksum: same frame with SUM=EC
    send(8'hA5, 0);
    check("bad_hdr_done",      {31'd0, load_done}, 32'd0);
    check("bad_hdr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    send(8'h01, 0);
    send(8'h78, 0);
    send(8'h56, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'hEC, 0);
    tick(1);
    check("bad_error",     {31'd0, load_error}, 32'd1);
    check("bad_done",      {31'd0, load_done},  32'd0);
    check("bad_cpu_reset", {31'd0, cpu_reset},  32'd1);

    // Noise, then a 2-word frame with random rx_valid gaps
    send(8'h00, 0);
    send(8'hFF, 1);
    send(8'h5A, 2);
    check("noise_error",     {31'd0, load_error}, 32'd1);
    check("noise_cpu_reset", {31'd0, cpu_reset},  32'd1);
    send(8'hA5, 1);
    check("w2_hdr_error", {31'd0, load_error}, 32'd0);
    send(8'h02, $urandom_range(0, 3));
    send(8'hEF, $urandom_range(0, 3));
    send(8'hBE, $urandom_range(0, 3));
    send(8'hAD, $urandom_range(0, 3));
    send(8'hDE, $urandom_range(0, 3));
    send(8'h0D, $urandom_range(0, 3));
    send(8'hF0, $urandom_range(0, 3));
    send(8'hAD, $urandom_range(0, 3));
    send(8'h0B, $urandom_range(0, 3));
    send(8'h11, $urandom_range(0, 3));
    tick(1);
    check("w2_done",      {31'd0, load_done},  32'd1);
    check("w2_error",     {31'd0, load_error}, 32'd0);
    check("w2_cpu_reset", {31'd0, cpu_reset},  32'd0);
    read_word(8'd0, 32'hDEADBEEF, "w2_word0");
    read_word(8'd1, 32'h0BADF00D, "w2_word1");

    // Full image: LEN=00, word k = k*0x01010101
    send(8'hA5, 0);
    send(8'h00, 0);
    acc = 8'h00;
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 4; j++) begin
        send(8'(k), 0);
        acc = acc + 8'(k);
      end
    end
    send(8'h00 - acc, 0);
    check("full_sumT_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    tick(1);
    check("full_done",      {31'd0, load_done},  32'd1);
    check("full_error",     {31'd0, load_error}, 32'd0);
    check("full_cpu_reset", {31'd0, cpu_reset},  32'd0);
    for (int k = 0; k < 256; k++) begin
      read_word(8'(k), 32'(k) * 32'h01010101, "full_word");
    end

    // Reload while running, including write-versus-read timing on address 0
    rom_addr = 8'd0;
    send(8'hA5, 0);
    check("rl_hdr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rl_hdr_done",      {31'd0, load_done}, 32'd0);
    send(8'h01, 0);
    send(8'h44, 0);
    send(8'h33, 0);
    send(8'h22, 0);
    send(8'h11, 0);
    check("rl_rd_T",   rom_data, 32'h00000000);
    tick(1);
    check("rl_rd_T1",  rom_data, 32'h00000000);
    tick(1);
    check("rl_rd_T2",  rom_data, 32'h11223344);
    send(8'h55, 0);
    tick(1);
    check("rl_done",      {31'd0, load_done}, 32'd1);
    check("rl_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    for (int k = 1; k < 256; k++) begin
      read_word(8'(k), 32'(k) * 32'h01010101, "rl_keep_word");
    end

    // Reset mid-frame: returns to reset values, RAM keeps the word already written
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    send(8'hDD, 0);
    reset = 1'b1;
    tick(2);
    check("mid_rx_ready",   {31'd0, rx_ready},   32'd0);
    check("mid_cpu_reset",  {31'd0, cpu_reset},  32'd1);
    check("mid_load_done",  {31'd0, load_done},  32'd0);
    check("mid_load_error", {31'd0, load_error}, 32'd0);
    check("mid_rom_data",   rom_data,            32'd0);
    reset = 1'b0;
    tick(1);
    check("mid_rel_rx_ready", {31'd0, rx_ready}, 32'd1);
    read_word(8'd0, 32'hDDCCBBAA, "mid_word0");
    read_word(8'd1, 32'h01010101, "mid_word1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
